// File: rtl/p405s_mac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : p405s_mac_pkg                                                   |
// | Purpose  : Shared types and constants for the MAC result stage:            |
// |            saturation limits, skid-buffer state encoding, buffered entry   |
// |            layout and the forwarding-extension helper.                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package p405s_mac_pkg;

    localparam logic [31:0] MAC_SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] MAC_SAT_NEG = 32'h8000_0000;
    localparam logic [31:0] MAC_SAT_U   = 32'hFFFF_FFFF;

    // Encoding equals the number of occupied entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [31:0] res;
        logic        ov;
        logic        ca;
        logic        sgn;
    } mac_entry_t;

    // 33-bit view of a stored result for the accumulate operand mux.
    function automatic logic [32:0] mac_fwd_ext(input mac_entry_t e);
        return e.sgn ? {e.res[31], e.res} : {1'b0, e.res};
    endfunction

endpackage
`default_nettype wire

// File: rtl/p405s_mac_result_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : p405s_mac_result_stage_if                                       |
// | Purpose  : Bundle of adder-side input, writeback handshake, control and    |
// |            forwarding signals of the MAC result stage.                     |
// | Ports    : master = adder/writeback/control side, slave = result stage.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface p405s_mac_result_stage_if;
    // adder side
    logic        in_valid;
    logic        in_ready;
    logic [32:0] sum;
    logic        co;
    logic        op_signed;
    logic        op_sat;
    logic        op_oe;
    // control
    logic        flush;
    logic        so_clr;
    logic        so;
    // writeback side
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        res_ov;
    logic        res_ca;
    // forwarding to accumulate operand mux
    logic        fwd_valid;
    logic [32:0] fwd_data;

    modport master (
        output in_valid, sum, co, op_signed, op_sat, op_oe, flush, so_clr, out_ready,
        input  in_ready, out_valid, res, res_ov, res_ca, so, fwd_valid, fwd_data
    );

    modport slave (
        input  in_valid, sum, co, op_signed, op_sat, op_oe, flush, so_clr, out_ready,
        output in_ready, out_valid, res, res_ov, res_ca, so, fwd_valid, fwd_data
    );
endinterface
`default_nettype wire

// File: rtl/p405s_mac_sat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : p405s_mac_sat                                                   |
// | Purpose  : Combinational overflow detection and optional saturation of    |
// |            the 33-bit adder sum down to 32 bits.                           |
// | Ports    : sum[32:0], op_signed, op_sat, op_oe in; res[31:0], ov out.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module p405s_mac_sat
    import p405s_mac_pkg::*;
(
    input  logic [32:0] sum,
    input  logic        op_signed,
    input  logic        op_sat,
    input  logic        op_oe,
    output logic [31:0] res,
    output logic        ov
);

    logic w_ov_raw;

    // Signed: extension bit disagrees with bit 31. Unsigned: any carry into bit 32.
    assign w_ov_raw = op_signed ? (sum[32] ^ sum[31]) : sum[32];

    always_comb begin
        res = sum[31:0];
        if (op_sat && w_ov_raw) begin
            if (op_signed) begin
                res = sum[32] ? MAC_SAT_NEG : MAC_SAT_POS;
            end else begin
                res = MAC_SAT_U;
            end
        end
    end

    assign ov = w_ov_raw & op_oe;

endmodule
`default_nettype wire

// File: rtl/p405s_mac_result_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : p405s_mac_result_stage                                          |
// | Purpose  : MAC result stage: overflow/saturation of the adder sum, 2-entry |
// |            skid buffer toward writeback, sticky summary overflow, and      |
// |            forwarding of the youngest buffered result.                     |
// | Ports    : cb (clock), reset (sync, active high), bus (slave modport).     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module p405s_mac_result_stage
    import p405s_mac_pkg::*;
#(
    parameter int DEPTH = 2     // only 2 is supported
) (
    input  logic                          cb,
    input  logic                          reset,
    p405s_mac_result_stage_if.slave       bus
);

    localparam logic [1:0] c_depth = 2'(DEPTH);

    logic [31:0] w_sat_res;
    logic        w_sat_ov;
    mac_entry_t  w_new;

    buf_state_t  r_state;
    buf_state_t  w_state_nxt;
    mac_entry_t  r_head;
    mac_entry_t  r_tail;
    mac_entry_t  w_head_nxt;
    mac_entry_t  w_tail_nxt;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_so;
    logic        w_accept;
    logic        w_retire;
    logic [1:0]  w_cnt_nxt;

    p405s_mac_sat u_sat (
        .sum       (bus.sum),
        .op_signed (bus.op_signed),
        .op_sat    (bus.op_sat),
        .op_oe     (bus.op_oe),
        .res       (w_sat_res),
        .ov        (w_sat_ov)
    );

    assign w_new = '{res: w_sat_res, ov: w_sat_ov, ca: bus.co, sgn: bus.op_signed};

    // FLUSH suppresses both sides so a flushed head can never set SO.
    assign w_accept = bus.in_valid & r_in_ready & ~bus.flush;
    assign w_retire = r_out_valid & bus.out_ready & ~bus.flush;

    // State register: buffer state, entries and the flop-driven handshakes.
    always_ff @(posedge cb) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_head      <= '0;
            r_tail      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_head      <= w_head_nxt;
            r_tail      <= w_tail_nxt;
            r_in_ready  <= (w_cnt_nxt < c_depth);
            r_out_valid <= (w_state_nxt != EMPTY);
        end
    end

    // Sticky summary overflow; a setting retire wins over a same-cycle clear.
    always_ff @(posedge cb) begin
        if (reset) begin
            r_so <= 1'b0;
        end else if (w_retire && r_head.ov) begin
            r_so <= 1'b1;
        end else if (bus.so_clr) begin
            r_so <= 1'b0;
        end
    end

    // Next-state and entry movement. Head is oldest, tail is youngest when FULL.
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ONE;
                    w_head_nxt  = w_new;
                end
            end
            ONE: begin
                if (w_accept && !w_retire) begin
                    w_state_nxt = FULL;
                    w_tail_nxt  = w_new;
                end else if (!w_accept && w_retire) begin
                    w_state_nxt = EMPTY;
                end else if (w_accept && w_retire) begin
                    w_head_nxt  = w_new;
                end
            end
            FULL: begin
                // in_ready is low here, so no accept can coincide with the retire.
                if (w_retire) begin
                    w_state_nxt = ONE;
                    w_head_nxt  = r_tail;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
        if (bus.flush) begin
            w_state_nxt = EMPTY;
        end
    end

    // Occupancy after this edge; the state encoding is the entry count.
    assign w_cnt_nxt = w_state_nxt;

    // Outputs: writeback sees the head, forwarding sees the youngest entry.
    always_comb begin
        bus.fwd_data = '0;
        case (r_state)
            ONE:     bus.fwd_data = mac_fwd_ext(r_head);
            FULL:    bus.fwd_data = mac_fwd_ext(r_tail);
            default: bus.fwd_data = '0;
        endcase
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.fwd_valid = r_out_valid;
    assign bus.res       = r_head.res;
    assign bus.res_ov    = r_head.ov;
    assign bus.res_ca    = r_head.ca;
    assign bus.so        = r_so;

endmodule
`default_nettype wire

// File: tb/tb_p405s_mac_result_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_p405s_mac_result_stage                                       |
// | Purpose  : Directed self-checking bench for the MAC result stage.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_p405s_mac_result_stage;

    logic cb;
    logic reset;
    int   n_cmp;
    int   n_fail;

    p405s_mac_result_stage_if bus ();

    p405s_mac_result_stage #(.DEPTH(2)) dut (
        .cb    (cb),
        .reset (reset),
        .bus   (bus)
    );

    initial cb = 1'b0;
    always #5 cb = ~cb;

    task automatic step();
        @(posedge cb);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
        chk({tag, "_so"},        64'(bus.so),        64'd0);
        chk({tag, "_res"},       64'(bus.res),       64'd0);
        chk({tag, "_res_ov"},    64'(bus.res_ov),    64'd0);
        chk({tag, "_res_ca"},    64'(bus.res_ca),    64'd0);
        chk({tag, "_fwd_valid"}, 64'(bus.fwd_valid), 64'd0);
        chk({tag, "_fwd_data"},  64'(bus.fwd_data),  64'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.sum = '0;
        bus.co = 1'b0;
        bus.op_signed = 1'b0;
        bus.op_sat = 1'b0;
        bus.op_oe = 1'b0;
        bus.flush = 1'b0;
        bus.so_clr = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk_reset_vals("rst");

        // Signed positive overflow saturates.
        reset = 1'b0;
        bus.in_valid = 1'b1; bus.sum = 33'h0_8000_0000;
        bus.op_signed = 1'b1; bus.op_sat = 1'b1; bus.op_oe = 1'b1;
        step();
        chk("s_pos_valid", 64'(bus.out_valid), 64'd1);
        chk("s_pos_res",   64'(bus.res),       64'h7FFF_FFFF);
        chk("s_pos_ov",    64'(bus.res_ov),    64'd1);
        chk("s_pos_fwd",   64'(bus.fwd_data),  64'h0_7FFF_FFFF);

        // Signed negative overflow, accepted while the previous head retires.
        bus.sum = 33'h1_7FFF_FFFF; bus.out_ready = 1'b1;
        step();
        chk("s_neg_res",   64'(bus.res),      64'h8000_0000);
        chk("s_neg_ov",    64'(bus.res_ov),   64'd1);
        chk("s_neg_fwd",   64'(bus.fwd_data), 64'h1_8000_0000);
        chk("so_set",      64'(bus.so),       64'd1);

        // SO_CLR alone clears.
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.so_clr = 1'b1;
        step();
        chk("so_clr",      64'(bus.so),       64'd0);
        chk("hold_valid",  64'(bus.out_valid), 64'd1);
        // SO_CLR with an OV retire: set wins.
        bus.out_ready = 1'b1;
        step();
        chk("so_set_wins", 64'(bus.so),        64'd1);
        chk("drain_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;
        step();
        chk("so_clr2",     64'(bus.so),        64'd0);
        bus.so_clr = 1'b0;

        // Unsigned overflow cases.
        bus.in_valid = 1'b1; bus.sum = 33'h1_0000_0005; bus.co = 1'b1;
        bus.op_signed = 1'b0; bus.op_sat = 1'b1; bus.op_oe = 1'b1; bus.out_ready = 1'b1;
        step();
        chk("u_sat_res",   64'(bus.res),      64'hFFFF_FFFF);
        chk("u_sat_ov",    64'(bus.res_ov),   64'd1);
        chk("u_sat_ca",    64'(bus.res_ca),   64'd1);
        chk("u_sat_fwd",   64'(bus.fwd_data), 64'h0_FFFF_FFFF);
        bus.op_sat = 1'b0;
        step();
        chk("u_wrap_res",  64'(bus.res),      64'h5);
        chk("u_wrap_ov",   64'(bus.res_ov),   64'd1);
        chk("u_wrap_ca",   64'(bus.res_ca),   64'd1);
        bus.op_oe = 1'b0;
        step();
        chk("u_noe_res",   64'(bus.res),      64'h5);
        chk("u_noe_ov",    64'(bus.res_ov),   64'd0);
        bus.in_valid = 1'b0; bus.so_clr = 1'b1;
        step();
        chk("u_drain",     64'(bus.out_valid), 64'd0);
        chk("u_so_clr",    64'(bus.so),        64'd0);
        bus.so_clr = 1'b0;

        // Backpressure: 1, 2 accepted, 3 held until writeback drains.
        bus.co = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.sum = 33'd1;
        step();
        chk("bp1_ready",   64'(bus.in_ready), 64'd1);
        chk("bp1_res",     64'(bus.res),      64'd1);
        bus.sum = 33'd2;
        step();
        chk("bp2_ready",   64'(bus.in_ready), 64'd0);
        chk("bp2_res",     64'(bus.res),      64'd1);
        chk("bp2_fwd",     64'(bus.fwd_data), 64'd2);
        bus.sum = 33'd3;
        step();
        chk("bp3_ready",   64'(bus.in_ready), 64'd0);
        chk("bp3_res_hold", 64'(bus.res),     64'd1);
        chk("bp3_fwd",     64'(bus.fwd_data), 64'd2);
        bus.out_ready = 1'b1;
        step();
        chk("bp_out2",     64'(bus.res),      64'd2);
        chk("bp_out2_rdy", 64'(bus.in_ready), 64'd1);
        step();
        chk("bp_out3",     64'(bus.res),      64'd3);
        chk("bp_out3_vld", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b0;
        step();
        chk("bp_empty",    64'(bus.out_valid), 64'd0);

        // Flush a FULL buffer holding two OV entries.
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.op_signed = 1'b1; bus.op_sat = 1'b0; bus.op_oe = 1'b1;
        bus.sum = 33'h0_8000_0000;
        step();
        bus.sum = 33'h1_7FFF_FFFF;
        step();
        chk("fl_full",     64'(bus.in_ready), 64'd0);
        chk("fl_head",     64'(bus.res),      64'h8000_0000);
        chk("fl_fwd",      64'(bus.fwd_data), 64'h0_7FFF_FFFF);
        bus.in_valid = 1'b0; bus.flush = 1'b1; bus.out_ready = 1'b1;
        step();
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_fwd_valid", 64'(bus.fwd_valid), 64'd0);
        chk("fl_so",        64'(bus.so),        64'd0);
        chk("fl_in_ready",  64'(bus.in_ready),  64'd1);
        bus.flush = 1'b0;

        // Reset in the middle of traffic.
        bus.op_signed = 1'b0; bus.op_oe = 1'b0; bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.sum = 33'h10;
        step();
        bus.sum = 33'h20; bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        step();
        chk("mr_full",     64'(bus.in_ready), 64'd0);
        reset = 1'b1; bus.out_ready = 1'b1; bus.sum = 33'h30;
        step();
        chk_reset_vals("mr");
        reset = 1'b0; bus.out_ready = 1'b0; bus.sum = 33'h44;
        step();
        chk("post_valid",  64'(bus.out_valid), 64'd1);
        chk("post_res",    64'(bus.res),       64'h44);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        step();
        chk("post_drain",  64'(bus.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
